regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side front end for `RegisterFile`: accepts results from the ALU and the load unit, buffers them, and drives the register file's single write port (`wsel`/`wdata`/`wen`). It keeps a per-register busy scoreboard for decode hazard stalls. It also forwards buffered, not-yet-committed results to decode, so a read in the same cycle as a commit returns the new value. It sits between execute/memory and `RegisterFile` in the core pipeline.

## Interface
- `XLEN`, 32, data width of results and register file.
- `DEPTH`, 2, result buffer entries (power of two, ≥2).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `issue_valid`  in  1  decode issued an instruction writing `issue_rd`.
- `issue_rd`  in  5  destination register of issued instruction.
- `alu_valid` / `alu_ready`  in / out  1  ALU result handshake.
- `alu_rd`, `alu_data`  in  5, XLEN  ALU destination and value.
- `mem_valid` / `mem_ready`  in / out  1  load result handshake.
- `mem_rd`, `mem_data`  in  5, XLEN  load destination and value.
- `wsel`  out  5  register file write select.
- `wdata`  out  XLEN  register file write data.
- `wen`  out  1  register file write enable.
- `busy`  out  32  bit i = write to xi pending (issued, not committed).
- `fwd_sel1`, `fwd_sel2`  in  5  decode read selects (same as `rsel1`/`rsel2`).
- `fwd_hit1`, `fwd_hit2`  out  1  buffered result exists for the select.
- `fwd_data1`, `fwd_data2`  out  XLEN  youngest buffered value for the select.

## Operation
- Result buffer: FIFO of `DEPTH` entries {rd, data}. Head drives `wsel`/`wdata`; `wen` = buffer non-empty.
- Every cycle with `wen`=1 commits the head: `RegisterFile` writes at the edge, and the head pops at the same edge. Throughput is one commit per cycle.
- Enqueue: at most one result per cycle.
  - `space` = (count < DEPTH) || `wen`.
  - `mem_ready` = `space`.
  - `alu_ready` = `space` && !`mem_valid`. Load has fixed priority; the ALU waits.
- A transfer occurs when valid && ready at the edge. `valid`, `rd` and `data` must be held stable until the transfer.
- rd = 0: the handshake completes normally, but nothing is enqueued and nothing is written. `wen` never asserts with `wsel`=0.
- Scoreboard:
  - `issue_valid` with `issue_rd`≠0 sets `busy[issue_rd]` at the edge.
  - A commit clears `busy[wsel]` at the edge.
  - If set and clear hit the same register in one cycle, set wins.
  - `busy[0]` is always 0.
  - Decode must not issue to a register that is already busy. Issuing to a busy register is a protocol error, and the bench asserts it never happens.
- Forwarding (combinational):
  - `fwd_hitN` = 1 if any buffer entry has rd == `fwd_selN` and `fwd_selN`≠0.
  - `fwd_dataN` = data of the youngest matching entry, else 0.
  - This includes the head being committed this cycle.
- Reset (async, immediate): buffer empty, `busy`=0, `wen`=0, `wsel`=0, `wdata`=0, `fwd_hit*`=0, `fwd_data*`=0, `alu_ready`=`mem_ready`=1 (while `mem_valid`=0).
- Reset mid-operation: all buffered results are discarded, no write is issued, and busy bits are lost. The pipeline is flushed by the same reset.

## Timing
- Result accepted at edge N → `wen`=1 with its rd/data during cycle N+1 (if the buffer was empty) → register updated at edge N+1 → combinational `RegisterFile` read shows it in cycle N+1 after the edge.
- Busy: set at issue edge; cleared at the commit edge. Decode sees `busy`=0 the cycle after commit.
- Full buffer with commit in progress: a new result is still accepted (pop and push at the same edge); count is unchanged.
- Full buffer and `wen`=0 cannot occur; the `space` term covers it.
- Order: commits occur in acceptance order; no reordering.
- No combinational path from `alu_valid` to `mem_ready`. `alu_ready` depends on `mem_valid` only.

## Test plan
- Reset, ALU result x5=0xDEADBEEF → `wen`=1, `wsel`=5, `wdata`=0xDEADBEEF one cycle after accept; `RegisterFile` read of x5 returns 0xDEADBEEF next cycle.
- `mem_valid` and `alu_valid` together (x10=0x12345678 load, x15=0xAAAAAAAA ALU) → `alu_ready`=0 that cycle; commits are x10 then x15 on consecutive cycles.
- Issue x15, then commit x15=1 → `busy[15]`=1 until the commit edge, then 0. In the same cycle, issue x15 again with commit x15 → `busy[15]` stays 1.
- Two results to x7 (0x1 then 0x2) buffered, `fwd_sel1`=7 → `fwd_hit1`=1, `fwd_data1`=0x2; `fwd_sel2`=8 → `fwd_hit2`=0, `fwd_data2`=0.
- ALU result with rd=0, data 0xFFFFFFFF → `alu_ready`=1, no `wen` ever asserted, x0 reads 0.
- Fill buffer with 2 results, assert `rst` mid-cycle → `wen`=0, `busy`=0 immediately. After release, `RegisterFile` contents are unchanged by the discarded results.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-side front end for the register file: buffers ALU/load results, drives the single
// write port, tracks per-register busy bits and forwards buffered results to decode.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic [4:0]      wsel,
    output logic [XLEN-1:0] wdata,
    output logic            wen,
    output logic [31:0]     busy,
    input  logic [4:0]      fwd_sel1,
    input  logic [4:0]      fwd_sel2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [4:0]      buf_rd   [DEPTH];
    logic [XLEN-1:0] buf_data [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     busy_q, busy_nxt;

    logic            space, mem_fire, alu_fire, push;
    logic [4:0]      push_rd;
    logic [XLEN-1:0] push_data;

    // Scan oldest to youngest so the last match left standing is the youngest entry.
    function automatic logic [XLEN:0] lookup(input logic [4:0] sel);
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q && sel != 5'd0 && buf_rd[idx] == sel)
                res = {1'b1, buf_data[idx]};
        end
        return res;
    endfunction

    // Only rd != 0 results are ever enqueued, so a non-empty buffer never writes x0.
    assign wen   = (count_q != '0);
    assign wsel  = wen ? buf_rd[head_q]   : 5'd0;
    assign wdata = wen ? buf_data[head_q] : '0;

    assign space     = (count_q < DEPTH_C) || wen;
    assign mem_ready = space;
    assign alu_ready = space && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    assign push      = (mem_fire && mem_rd != 5'd0) || (alu_fire && alu_rd != 5'd0);
    assign push_rd   = mem_fire ? mem_rd   : alu_rd;
    assign push_data = mem_fire ? mem_data : alu_data;

    assign {fwd_hit1, fwd_data1} = lookup(fwd_sel1);
    assign {fwd_hit2, fwd_data2} = lookup(fwd_sel2);

    // Clear on commit first, then set on issue, so a same-cycle issue wins.
    always_comb begin
        busy_nxt = busy_q;
        if (wen)
            busy_nxt[wsel] = 1'b0;
        if (issue_valid)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign busy = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (wen)
                head_q <= head_q + 1'b1;
            if (push)
                tail_q <= tail_q + 1'b1;
            case ({push, wen})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_rd[tail_q]   <= push_rd;
            buf_data[tail_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, reset sequences and
// randomized traffic against a queue-based reference model with a register file copy.
module tb_regfile_writeback;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid, mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic [4:0]      wsel;
    logic [XLEN-1:0] wdata;
    logic            wen;
    logic [31:0]     busy;
    logic [4:0]      fwd_sel1, fwd_sel2;
    logic            fwd_hit1, fwd_hit2;
    logic [XLEN-1:0] fwd_data1, fwd_data2;

    regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wsel(wsel), .wdata(wdata), .wen(wen), .busy(busy),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic iv; logic [4:0] ird;
        logic mv; logic [4:0] mrd; logic [31:0] md;
        logic av; logic [4:0] ard; logic [31:0] ad;
        logic [4:0] s1, s2;
        logic e_wen; logic [4:0] e_wsel; logic [31:0] e_wdata;
        logic e_ar, e_mr;
        logic e_h1; logic [31:0] e_d1;
        logic e_h2; logic [31:0] e_d2;
        logic [31:0] e_busy;
        logic [4:0] rf_sel; logic [31:0] rf_val;
    } vec_t;

    int          n_vec  = 0;
    int          n_miss = 0;
    ent_t        q[$];
    logic [31:0] bm;
    logic [31:0] rf_ref [32];
    logic [31:0] rf_dut [32];
    logic        mf_m, af_m;
    vec_t        vt[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(logic iv, logic [4:0] ird,
                                logic mv, logic [4:0] mrd, logic [31:0] md,
                                logic av, logic [4:0] ard, logic [31:0] ad,
                                logic [4:0] s1, logic [4:0] s2,
                                logic e_wen, logic [4:0] e_wsel, logic [31:0] e_wdata,
                                logic e_ar, logic e_mr,
                                logic e_h1, logic [31:0] e_d1, logic e_h2, logic [31:0] e_d2,
                                logic [31:0] e_busy, logic [4:0] rf_sel, logic [31:0] rf_val);
        vec_t v;
        v.iv = iv; v.ird = ird; v.mv = mv; v.mrd = mrd; v.md = md;
        v.av = av; v.ard = ard; v.ad = ad; v.s1 = s1; v.s2 = s2;
        v.e_wen = e_wen; v.e_wsel = e_wsel; v.e_wdata = e_wdata;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_h1 = e_h1; v.e_d1 = e_d1;
        v.e_h2 = e_h2; v.e_d2 = e_d2; v.e_busy = e_busy;
        v.rf_sel = rf_sel; v.rf_val = rf_val;
        return v;
    endfunction

    // One clock cycle: starts just after a falling edge with inputs already driven.
    task automatic step();
        logic        e_wen, e_space, h1, h2;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdata, d1, d2;
        #1;
        e_wen = (q.size() > 0);
        e_wsel = 5'd0;
        e_wdata = 32'd0;
        if (e_wen) begin
            e_wsel = q[0].rd;
            e_wdata = q[0].data;
        end
        e_space = (q.size() < DEPTH) || e_wen;
        h1 = 1'b0; d1 = 32'd0; h2 = 1'b0; d2 = 32'd0;
        foreach (q[i]) begin
            if (fwd_sel1 != 5'd0 && q[i].rd == fwd_sel1) begin h1 = 1'b1; d1 = q[i].data; end
            if (fwd_sel2 != 5'd0 && q[i].rd == fwd_sel2) begin h2 = 1'b1; d2 = q[i].data; end
        end
        chk("wen", 32'(wen), 32'(e_wen));
        chk("wsel", 32'(wsel), 32'(e_wsel));
        chk("wdata", wdata, e_wdata);
        chk("mem_ready", 32'(mem_ready), 32'(e_space));
        chk("alu_ready", 32'(alu_ready), 32'(e_space && !mem_valid));
        chk("busy", busy, bm);
        chk("fwd_hit1", 32'(fwd_hit1), 32'(h1));
        chk("fwd_data1", fwd_data1, d1);
        chk("fwd_hit2", 32'(fwd_hit2), 32'(h2));
        chk("fwd_data2", fwd_data2, d2);
        if (issue_valid && issue_rd != 5'd0)
            chk("issue_not_busy", 32'(busy[issue_rd]), 32'd0);
        if (wen)
            rf_dut[wsel] = wdata;
        @(posedge clk);
        mf_m = mem_valid && e_space;
        af_m = alu_valid && e_space && !mem_valid;
        if (e_wen) begin
            rf_ref[q[0].rd] = q[0].data;
            bm[q[0].rd] = 1'b0;
            void'(q.pop_front());
        end
        if (mf_m && mem_rd != 5'd0) q.push_back('{rd: mem_rd, data: mem_data});
        if (af_m && alu_rd != 5'd0) q.push_back('{rd: alu_rd, data: alu_data});
        if (issue_valid && issue_rd != 5'd0) bm[issue_rd] = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = '0;
        fwd_sel1 = 5'd0; fwd_sel2 = 5'd0;
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_wen"}, 32'(wen), 32'd0);
        chk({tag, "_wsel"}, 32'(wsel), 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_fwd_hit1"}, 32'(fwd_hit1), 32'd0);
        chk({tag, "_fwd_data1"}, fwd_data1, 32'd0);
        chk({tag, "_alu_ready"}, 32'(alu_ready), 32'd1);
        chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
    endtask

    initial begin
        logic [4:0] r;
        bm = 32'd0;
        for (int i = 0; i < 32; i++) begin rf_ref[i] = 32'd0; rf_dut[i] = 32'd0; end
        idle_inputs();
        rst = 1'b1;
        #1;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: expected outputs are those seen during the cycle, before its edge.
        vt.push_back(mk(1,5,  0,0,0,             1,5,32'hDEADBEEF, 5,0,  0,0,0,             1,1, 0,0,0,0,             32'd0,      0,0));
        vt.push_back(mk(0,0,  0,0,0,             0,0,0,            5,0,  1,5,32'hDEADBEEF,  1,1, 1,32'hDEADBEEF,0,0,  32'h20,     0,0));
        vt.push_back(mk(0,0,  0,0,0,             0,0,0,            5,0,  0,0,0,             1,1, 0,0,0,0,             32'd0,      5,32'hDEADBEEF));
        vt.push_back(mk(0,0,  1,10,32'h12345678, 1,15,32'hAAAAAAAA,10,15, 0,0,0,            0,1, 0,0,0,0,             32'd0,      0,0));
        vt.push_back(mk(0,0,  0,0,0,             1,15,32'hAAAAAAAA,10,15, 1,10,32'h12345678,1,1, 1,32'h12345678,0,0,  32'd0,      0,0));
        vt.push_back(mk(0,0,  0,0,0,             0,0,0,            10,15, 1,15,32'hAAAAAAAA,1,1, 0,0,1,32'hAAAAAAAA,  32'd0,      10,32'h12345678));
        vt.push_back(mk(1,15, 0,0,0,             0,0,0,            15,0,  0,0,0,            1,1, 0,0,0,0,             32'd0,      15,32'hAAAAAAAA));
        vt.push_back(mk(0,0,  0,0,0,             1,15,32'h1,       15,0,  0,0,0,            1,1, 0,0,0,0,             32'h8000,   0,0));
        vt.push_back(mk(0,0,  0,0,0,             0,0,0,            15,0,  1,15,32'h1,       1,1, 1,32'h1,0,0,         32'h8000,   0,0));
        vt.push_back(mk(0,0,  0,0,0,             1,15,32'h2,       15,0,  0,0,0,            1,1, 0,0,0,0,             32'd0,      15,32'h1));
        vt.push_back(mk(1,15, 0,0,0,             0,0,0,            15,0,  1,15,32'h2,       1,1, 1,32'h2,0,0,         32'd0,      0,0));
        vt.push_back(mk(0,0,  0,0,0,             0,0,0,            15,0,  0,0,0,            1,1, 0,0,0,0,             32'h8000,   15,32'h2));
        vt.push_back(mk(0,0,  0,0,0,             1,7,32'h1,        7,8,   0,0,0,            1,1, 0,0,0,0,             32'h8000,   0,0));
        vt.push_back(mk(0,0,  0,0,0,             1,7,32'h2,        7,8,   1,7,32'h1,        1,1, 1,32'h1,0,0,         32'h8000,   0,0));
        vt.push_back(mk(0,0,  0,0,0,             0,0,0,            7,8,   1,7,32'h2,        1,1, 1,32'h2,0,0,         32'h8000,   7,32'h1));
        vt.push_back(mk(0,0,  0,0,0,             1,0,32'hFFFFFFFF, 0,0,   0,0,0,            1,1, 0,0,0,0,             32'h8000,   7,32'h2));
        vt.push_back(mk(0,0,  1,0,32'hFFFFFFFF,  1,3,32'h3,        0,0,   0,0,0,            0,1, 0,0,0,0,             32'h8000,   0,0));
        vt.push_back(mk(0,0,  0,0,0,             1,3,32'h3,        3,0,   0,0,0,            1,1, 0,0,0,0,             32'h8000,   0,0));
        vt.push_back(mk(0,0,  0,0,0,             0,0,0,            3,0,   1,3,32'h3,        1,1, 1,32'h3,0,0,         32'h8000,   0,0));

        foreach (vt[i]) begin
            issue_valid = vt[i].iv; issue_rd = vt[i].ird;
            mem_valid = vt[i].mv; mem_rd = vt[i].mrd; mem_data = vt[i].md;
            alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
            fwd_sel1 = vt[i].s1; fwd_sel2 = vt[i].s2;
            #1;
            chk("vec_wen", 32'(wen), 32'(vt[i].e_wen));
            chk("vec_wsel", 32'(wsel), 32'(vt[i].e_wsel));
            chk("vec_wdata", wdata, vt[i].e_wdata);
            chk("vec_alu_ready", 32'(alu_ready), 32'(vt[i].e_ar));
            chk("vec_mem_ready", 32'(mem_ready), 32'(vt[i].e_mr));
            chk("vec_fwd_hit1", 32'(fwd_hit1), 32'(vt[i].e_h1));
            chk("vec_fwd_data1", fwd_data1, vt[i].e_d1);
            chk("vec_fwd_hit2", 32'(fwd_hit2), 32'(vt[i].e_h2));
            chk("vec_fwd_data2", fwd_data2, vt[i].e_d2);
            chk("vec_busy", busy, vt[i].e_busy);
            chk("vec_rf_read", rf_dut[vt[i].rf_sel], vt[i].rf_val);
            step();
        end
        idle_inputs();

        // Reset while a result is buffered and about to commit.
        issue_valid = 1'b1; issue_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
        step();
        idle_inputs();
        fwd_sel1 = 5'd9;
        #1;
        chk("pre_reset_wen", 32'(wen), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("midreset");
        q.delete();
        bm = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        chk("discarded_x9", rf_dut[9], 32'd0);

        // Randomized traffic with held valid/rd/data until each transfer.
        for (int c = 0; c < 800; c++) begin
            if (!mem_valid && $urandom_range(0, 2) == 0) begin
                mem_valid = 1'b1; mem_rd = 5'($urandom_range(0, 31)); mem_data = $urandom;
            end
            if (!alu_valid && $urandom_range(0, 1) == 0) begin
                alu_valid = 1'b1; alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
            end
            r = 5'($urandom_range(0, 31));
            issue_rd = r;
            issue_valid = ($urandom_range(0, 1) == 1) && !bm[r];
            fwd_sel1 = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[q.size()-1].rd : 5'($urandom_range(0, 31));
            fwd_sel2 = 5'($urandom_range(0, 31));
            step();
            if (mf_m) mem_valid = 1'b0;
            if (af_m) alu_valid = 1'b0;
        end
        idle_inputs();
        step();
        step();
        for (int i = 0; i < 32; i++)
            chk("regfile_final", rf_dut[i], rf_ref[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
